scs8hd_sdfrtn_bank: RTL and testbench
=====================================

# scs8hd_sdfrtn_bank

Parametrised multi-bit scan register with a negative-edge clock and asynchronous active-low reset. It generalises the single-bit mux-scan reset flop into a WIDTH-bit bank with three per-edge modes: parallel capture, hold, and serial shift. It adds an automatic full-chain scan sequencer that shifts exactly WIDTH bits on request and reports completion. It sits at register-file and scan-chain boundaries, where a whole word must be captured functionally or unloaded and loaded serially by test logic.

## Interface
Parameters:
- WIDTH, 8, number of bank bits; legal range 2..64.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into Q on reset.
- CW, $clog2(WIDTH+1), width of SHIFT_CNT (derived; do not override).

Ports:
- CLKN  in  1  clock; all state updates on the falling edge.
- RESETB  in  1  reset; asynchronous, active-low.
- D  in  WIDTH  parallel functional data.
- DE  in  1  data enable; capture D when high.
- SCE  in  1  manual scan enable; one shift per edge when high.
- SCD  in  1  serial scan input.
- SCAN_REQ  in  1  request an automatic WIDTH-bit shift sequence.
- Q  out  WIDTH  register contents.
- SCO  out  1  serial scan output, equal to Q[WIDTH-1] (combinational from Q).
- SCAN_BUSY  out  1  high while the sequencer is in SHIFT or DONE.
- SCAN_DONE  out  1  one-edge pulse marking the end of a sequence.
- SHIFT_CNT  out  CW  number of bits shifted in the current sequence.

## Operation
- Shift operation: Q <= {Q[WIDTH-2:0], SCD}. Bit 0 receives SCD; Q[WIDTH-1] leaves on SCO.
- Per-edge priority for Q:
  1. RESETB low.
  2. Sequencer in SHIFT: shift.
  3. SCE high: shift.
  4. DE high: Q <= D.
  5. Otherwise: hold.
- While in SHIFT, SCE and DE are ignored.
- Sequencer states:
  - IDLE: SCAN_REQ high at an edge -> go to SHIFT with SHIFT_CNT=0. Q follows the normal priority on that same edge, so the request edge does not itself shift.
  - SHIFT: each edge shifts Q and increments SHIFT_CNT. On the edge where SHIFT_CNT==WIDTH-1, SHIFT_CNT becomes WIDTH and the state goes to DONE.
  - DONE: lasts one edge; SCAN_DONE=1 and SHIFT_CNT=WIDTH. Q follows the normal priority (SCE/DE are honoured). The next edge goes to IDLE and clears SHIFT_CNT to 0.
- SCAN_REQ is level-sampled only in IDLE; it is ignored in SHIFT and DONE. If SCAN_REQ is still high on return to IDLE, a new sequence starts on the following edge.
- Exactly WIDTH shifts per sequence: after completion, Q holds the last WIDTH SCD bits, and the original Q has appeared on SCO MSB-first.
- SCAN_BUSY = (state != IDLE). SCAN_BUSY, SCAN_DONE and SHIFT_CNT are registered.

## Timing
- Reset values: Q=RESET_VAL, SCO=RESET_VAL[WIDTH-1], SCAN_BUSY=0, SCAN_DONE=0, SHIFT_CNT=0, state IDLE.
- Reset assertion acts immediately, independent of CLKN.
- Release: the first active edge is the first falling CLKN edge with RESETB high.
- Reset asserted mid-sequence: the sequence aborts immediately with all reset values; no SCAN_DONE is produced.
- Latency:
  - Capture and manual shift: Q is updated at the falling edge on which the input was sampled.
  - SCAN_REQ to SCAN_BUSY: 1 edge.
  - SCAN_REQ to SCAN_DONE: WIDTH+1 edges.
  - Total busy span: WIDTH+1 edges (WIDTH SHIFT edges plus 1 DONE edge).
- Inputs must meet setup/hold to the falling CLKN edge. Gating conditions for timing checks:
  - DE and SCE setup/hold only when RESETB is high.
  - SCD only when a shift is selected.
  - D only when a capture is selected.
- Minimum CLKN high and low widths, and RESETB low width, are library-characterised. A violation drives Q to X.

## Test plan
- Reset: RESETB low mid-clock with RESET_VAL=8'hA5 -> Q=8'hA5, SCO=1, SCAN_BUSY=0, SHIFT_CNT=0 immediately, without any CLKN edge.
- Capture/hold: D=8'h3C with DE=1 for one edge, then DE=0 with D=8'hFF -> Q=8'h3C after the first edge and still 8'h3C after the second.
- Manual shift and priority: Q=8'h81, SCE=1, DE=1, SCD=0 for one edge -> Q=8'h02 (shift wins over capture); SCO goes 1 then 0.
- Auto sequence: Q=8'hC3, SCAN_REQ pulsed for one edge, SCD stream 1,0,1,0,1,0,1,0, DE=1 throughout:
  - SCAN_BUSY rises after 1 edge and SHIFT_CNT counts 1..8.
  - SCO emits 1,1,0,0,0,0,1,1.
  - After 8 shifts Q=8'hAA; SCAN_DONE pulses on edge 9; DE capture resumes on the DONE edge.
- Back-to-back: SCAN_REQ held high -> DONE, then IDLE for one edge, then SHIFT again. SHIFT_CNT reads 8 -> 0 -> 0 -> 1.
- Abort: RESETB low after 3 shifts of a sequence -> SCAN_BUSY=0 and Q=RESET_VAL immediately. After release, no SCAN_DONE appears and the sequencer is idle.

Source files
------------

// File: rtl/scs8hd_sdfrtn_bank_if.sv
// scs8hd_sdfrtn_bank_if: bus bundle for the scan register bank.
// Signals: D/DE capture, SCE/SCD manual shift, SCAN_REQ sequencer request,
// Q/SCO contents and serial output, SCAN_BUSY/SCAN_DONE/SHIFT_CNT sequencer status.
interface scs8hd_sdfrtn_bank_if #(
    parameter int WIDTH = 8,
    parameter int CW = $clog2(WIDTH + 1)
);
    logic [WIDTH-1:0] D;
    logic             DE;
    logic             SCE;
    logic             SCD;
    logic             SCAN_REQ;
    logic [WIDTH-1:0] Q;
    logic             SCO;
    logic             SCAN_BUSY;
    logic             SCAN_DONE;
    logic [CW-1:0]    SHIFT_CNT;
    modport master (
        output D, DE, SCE, SCD, SCAN_REQ,
        input  Q, SCO, SCAN_BUSY, SCAN_DONE, SHIFT_CNT
    );
    modport slave (
        input  D, DE, SCE, SCD, SCAN_REQ,
        output Q, SCO, SCAN_BUSY, SCAN_DONE, SHIFT_CNT
    );
endinterface

// File: rtl/scs8hd_sdfrtn_bank.sv
// scs8hd_sdfrtn_bank: WIDTH-bit negedge mux-scan register bank with full-chain scan sequencer.
// Ports: CLKN falling-edge clock, RESETB async active-low reset,
// bus (slave): D/DE capture, SCE/SCD shift, SCAN_REQ auto-shift request,
// Q/SCO contents, SCAN_BUSY/SCAN_DONE/SHIFT_CNT sequencer status.
module scs8hd_sdfrtn_bank #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int CW = $clog2(WIDTH + 1)
) (
    input logic CLKN,
    input logic RESETB,
    scs8hd_sdfrtn_bank_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state, state_nx;
    logic [CW-1:0]    cnt_nx;
    logic [WIDTH-1:0] q_nx;
    always_comb begin
        state_nx = state;
        cnt_nx   = bus.SHIFT_CNT;
        case (state)
            IDLE: begin
                cnt_nx   = '0;
                state_nx = bus.SCAN_REQ ? SHIFT : IDLE;
            end
            SHIFT: begin
                cnt_nx   = bus.SHIFT_CNT + 1'b1;
                state_nx = (bus.SHIFT_CNT == CW'(WIDTH - 1)) ? DONE : SHIFT;
            end
            default: begin
                cnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
        // The sequencer owns the shift path while in SHIFT, overriding SCE/DE.
        q_nx = (state == SHIFT || bus.SCE) ? {bus.Q[WIDTH-2:0], bus.SCD} :
               bus.DE ? bus.D : bus.Q;
    end
    always_ff @(negedge CLKN or negedge RESETB) begin
        if (!RESETB) begin
            state         <= IDLE;
            bus.SHIFT_CNT <= '0;
            bus.Q         <= RESET_VAL;
        end else begin
            state         <= state_nx;
            bus.SHIFT_CNT <= cnt_nx;
            bus.Q         <= q_nx;
        end
    end
    assign bus.SCO       = bus.Q[WIDTH-1];
    assign bus.SCAN_BUSY = (state != IDLE);
    assign bus.SCAN_DONE = (state == DONE);
endmodule

// File: tb/tb_scs8hd_sdfrtn_bank.sv
// tb_scs8hd_sdfrtn_bank: directed self-checking bench for scs8hd_sdfrtn_bank (WIDTH=8, RESET_VAL=8'hA5).
module tb_scs8hd_sdfrtn_bank;
    logic CLKN = 1'b1;
    logic RESETB;
    int checks = 0;
    int failures = 0;
    logic [7:0] src;
    scs8hd_sdfrtn_bank_if #(.WIDTH(8)) bus ();
    scs8hd_sdfrtn_bank #(.WIDTH(8), .RESET_VAL(8'hA5)) dut (
        .CLKN(CLKN),
        .RESETB(RESETB),
        .bus(bus)
    );
    always #5 CLKN = ~CLKN;
    task automatic edge_();
        @(negedge CLKN);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    initial begin
        bus.D = 8'h12; bus.DE = 1; bus.SCE = 0; bus.SCD = 0; bus.SCAN_REQ = 0;
        RESETB = 1;
        edge_();
        chk("pre_q", bus.Q, 8'h12);
        #2 RESETB = 0;
        #1;
        chk("rst_q", bus.Q, 8'hA5);
        chk("rst_sco", bus.SCO, 1);
        chk("rst_busy", bus.SCAN_BUSY, 0);
        chk("rst_done", bus.SCAN_DONE, 0);
        chk("rst_cnt", bus.SHIFT_CNT, 0);
        edge_();
        chk("rst_hold_q", bus.Q, 8'hA5);
        RESETB = 1;
        bus.D = 8'h3C; bus.DE = 1;
        edge_();
        chk("cap_q", bus.Q, 8'h3C);
        bus.D = 8'hFF; bus.DE = 0;
        edge_();
        chk("hold_q", bus.Q, 8'h3C);
        bus.D = 8'h81; bus.DE = 1;
        edge_();
        chk("load81_q", bus.Q, 8'h81);
        chk("load81_sco", bus.SCO, 1);
        bus.SCE = 1; bus.DE = 1; bus.D = 8'hFF; bus.SCD = 0;
        edge_();
        chk("mshift_q", bus.Q, 8'h02);
        chk("mshift_sco", bus.SCO, 0);
        bus.SCE = 0; bus.D = 8'hC3; bus.DE = 1;
        edge_();
        chk("loadC3_q", bus.Q, 8'hC3);
        bus.SCAN_REQ = 1;
        edge_();
        chk("req_busy", bus.SCAN_BUSY, 1);
        chk("req_cnt", bus.SHIFT_CNT, 0);
        chk("req_q", bus.Q, 8'hC3);
        bus.SCAN_REQ = 0; bus.D = 8'h00;
        src = 8'hC3;
        for (int i = 0; i < 8; i++) begin
            bus.SCD = (i % 2 == 0);
            chk("seq_sco", bus.SCO, src[7-i]);
            edge_();
            chk("seq_cnt", bus.SHIFT_CNT, i + 1);
            chk("seq_busy", bus.SCAN_BUSY, 1);
            chk("seq_done", bus.SCAN_DONE, (i == 7));
        end
        chk("seq_q", bus.Q, 8'hAA);
        bus.D = 8'h5A;
        edge_();
        chk("done_cap_q", bus.Q, 8'h5A);
        chk("done_busy", bus.SCAN_BUSY, 0);
        chk("done_done", bus.SCAN_DONE, 0);
        chk("done_cnt", bus.SHIFT_CNT, 0);
        bus.DE = 0; bus.SCAN_REQ = 1;
        edge_();
        repeat (8) edge_();
        chk("b2b_cnt8", bus.SHIFT_CNT, 8);
        chk("b2b_done", bus.SCAN_DONE, 1);
        edge_();
        chk("b2b_idle_cnt", bus.SHIFT_CNT, 0);
        chk("b2b_idle_busy", bus.SCAN_BUSY, 0);
        edge_();
        chk("b2b_req_cnt", bus.SHIFT_CNT, 0);
        chk("b2b_req_busy", bus.SCAN_BUSY, 1);
        edge_();
        chk("b2b_cnt1", bus.SHIFT_CNT, 1);
        bus.SCAN_REQ = 0;
        repeat (2) edge_();
        chk("abort_pre_cnt", bus.SHIFT_CNT, 3);
        #2 RESETB = 0;
        #1;
        chk("abort_busy", bus.SCAN_BUSY, 0);
        chk("abort_q", bus.Q, 8'hA5);
        chk("abort_cnt", bus.SHIFT_CNT, 0);
        #3 RESETB = 1;
        for (int i = 0; i < 10; i++) begin
            edge_();
            chk("post_abort_done", bus.SCAN_DONE, 0);
            chk("post_abort_busy", bus.SCAN_BUSY, 0);
        end
        chk("post_abort_q", bus.Q, 8'hA5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
